// File: rtl/ps2_cmd_scheduler_if.sv
// Byte-channel bundle between command sources, PS/2 PHY and scheduler.
// Optional statistics signals exist only with PS2_SCHED_STATS_EN.
interface ps2_cmd_scheduler_if;
  logic       CMD_WR;
  logic [7:0] CMD_DATA;
  logic       CMD_FULL;
  logic       CMD_EMPTY;
  logic       PRIO_REQ;
  logic [7:0] PRIO_BYTE;
  logic       PRIO_ACK;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic       BYTE_READY;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BUSY;
  logic       CMD_DONE;
  logic       CMD_FAIL;
  logic [7:0] LAST_RESP;
`ifdef PS2_SCHED_STATS_EN
  logic [7:0] FAIL_COUNT;
  logic [7:0] RETRY_COUNT;
`endif

  modport master (
    input  CMD_WR, CMD_DATA, PRIO_REQ, PRIO_BYTE,
    input  BYTE_SENT, BYTE_READ, BYTE_READY,
    input  BYTE_ERROR_CODE,
    output CMD_FULL, CMD_EMPTY, PRIO_ACK,
    output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    output BUSY, CMD_DONE, CMD_FAIL, LAST_RESP
`ifdef PS2_SCHED_STATS_EN
    , output FAIL_COUNT, RETRY_COUNT
`endif
  );

  modport slave (
    output CMD_WR, CMD_DATA, PRIO_REQ, PRIO_BYTE,
    output BYTE_SENT, BYTE_READ, BYTE_READY,
    output BYTE_ERROR_CODE,
    input  CMD_FULL, CMD_EMPTY, PRIO_ACK,
    input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    input  BUSY, CMD_DONE, CMD_FAIL, LAST_RESP
`ifdef PS2_SCHED_STATS_EN
    , input FAIL_COUNT, RETRY_COUNT
`endif
  );
endinterface

// File: rtl/ps2_cmd_scheduler.sv
// PS/2 host command scheduler: FIFO + priority byte, send/ack/retry FSM.
// Define PS2_SCHED_STATS_EN to add FAIL_COUNT / RETRY_COUNT outputs.
module ps2_cmd_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int ADDR_W         = 2,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int MAX_RETRIES    = 3
) (
  input logic CLK,
  input logic RESET,
  ps2_cmd_scheduler_if.master bus
);
  localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int RWC = $clog2(MAX_RETRIES + 1);
  localparam int RW  = (RWC < 1) ? 1 : RWC;
  localparam int CW  = ADDR_W + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);
  localparam logic [CW-1:0] F_MAX  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_SENT, S_WAIT_ACK,
    S_RETRY, S_DONE, S_FAIL
  } state_t;

  state_t            state;
  logic [7:0]        cur_byte;
  logic [RW-1:0]     retry_cnt;
  logic [TW-1:0]     timer;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic              wr_ok;
  logic              pop;

  // Qualify FIFO push/pop and compute next occupancy
  always_comb begin
    wr_ok = bus.CMD_WR && !bus.CMD_FULL;
    pop = (state == S_IDLE) && !bus.PRIO_REQ
          && !bus.CMD_EMPTY;
    count_nxt = count;
    if (wr_ok && !pop)
      count_nxt = count + CW'(1);
    else if (!wr_ok && pop)
      count_nxt = count - CW'(1);
  end

  // FIFO storage; contents need no reset
  always_ff @(posedge CLK) begin
    if (wr_ok)
      mem[wr_ptr] <= bus.CMD_DATA;
  end

  // FIFO pointers, occupancy and registered flags
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.CMD_FULL  <= 1'b0;
      bus.CMD_EMPTY <= 1'b1;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      count         <= count_nxt;
      bus.CMD_FULL  <= (count_nxt == F_MAX);
      bus.CMD_EMPTY <= (count_nxt == '0);
    end
  end

  // Send / wait-ack / retry sequencer with registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state            <= S_IDLE;
      cur_byte         <= '0;
      retry_cnt        <= '0;
      timer            <= '0;
      bus.PRIO_ACK     <= 1'b0;
      bus.SEND_BYTE    <= 1'b0;
      bus.BYTE_TO_SEND <= '0;
      bus.READ_ENABLE  <= 1'b0;
      bus.BUSY         <= 1'b0;
      bus.CMD_DONE     <= 1'b0;
      bus.CMD_FAIL     <= 1'b0;
      bus.LAST_RESP    <= '0;
`ifdef PS2_SCHED_STATS_EN
      bus.FAIL_COUNT   <= '0;
      bus.RETRY_COUNT  <= '0;
`endif
    end else begin
      bus.PRIO_ACK    <= 1'b0;
      bus.SEND_BYTE   <= 1'b0;
      bus.CMD_DONE    <= 1'b0;
      bus.CMD_FAIL    <= 1'b0;
      bus.READ_ENABLE <= 1'b0;
      bus.BUSY        <= 1'b1;
      unique case (state)
        S_IDLE: begin
          timer    <= '0;
          bus.BUSY <= 1'b0;
          if (bus.PRIO_REQ) begin
            cur_byte     <= bus.PRIO_BYTE;
            bus.PRIO_ACK <= 1'b1;
            retry_cnt    <= '0;
            bus.BUSY     <= 1'b1;
            state        <= S_LOAD;
          end else if (!bus.CMD_EMPTY) begin
            cur_byte  <= mem[rd_ptr];
            retry_cnt <= '0;
            bus.BUSY  <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          bus.SEND_BYTE    <= 1'b1;
          bus.BYTE_TO_SEND <= cur_byte;
          timer            <= '0;
          state            <= S_WAIT_SENT;
        end
        S_WAIT_SENT: begin
          if (bus.BYTE_SENT) begin
            timer           <= '0;
            bus.READ_ENABLE <= 1'b1;
            state           <= S_WAIT_ACK;
          end else if (timer == T_LAST) begin
            timer <= '0;
            state <= S_RETRY;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_WAIT_ACK: begin
          if (bus.BYTE_ERROR_CODE != 2'b00) begin
            timer <= '0;
            state <= S_RETRY;
          end else if (bus.BYTE_READY) begin
            bus.LAST_RESP <= bus.BYTE_READ;
            timer         <= '0;
            if (bus.BYTE_READ == 8'hFA) begin
              bus.CMD_DONE <= 1'b1;
              state        <= S_DONE;
            end else begin
              state <= S_RETRY;
            end
          end else if (timer == T_LAST) begin
            timer <= '0;
            state <= S_RETRY;
          end else begin
            timer           <= timer + TW'(1);
            bus.READ_ENABLE <= 1'b1;
          end
        end
        S_RETRY: begin
          timer <= '0;
          if (retry_cnt < R_MAX) begin
            retry_cnt <= retry_cnt + RW'(1);
            state     <= S_LOAD;
`ifdef PS2_SCHED_STATS_EN
            if (bus.RETRY_COUNT != 8'hFF)
              bus.RETRY_COUNT <= bus.RETRY_COUNT + 8'd1;
`endif
          end else begin
            bus.CMD_FAIL <= 1'b1;
            state        <= S_FAIL;
`ifdef PS2_SCHED_STATS_EN
            if (bus.FAIL_COUNT != 8'hFF)
              bus.FAIL_COUNT <= bus.FAIL_COUNT + 8'd1;
`endif
          end
        end
        S_DONE: begin
          timer    <= '0;
          bus.BUSY <= 1'b0;
          state    <= S_IDLE;
        end
        S_FAIL: begin
          timer    <= '0;
          bus.BUSY <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          timer    <= '0;
          bus.BUSY <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Bench for ps2_cmd_scheduler: vector table plus directed corner sequences.
// A small responder plays the PS/2 PHY from a queue of canned responses.
module tb_ps2_cmd_scheduler;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  ps2_cmd_scheduler_if ifc();

  ps2_cmd_scheduler #(
    .FIFO_DEPTH(4),
    .ADDR_W(2),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRIES(3)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(ifc.master)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Monitor: pulse counters and log of transmitted bytes
  logic [7:0] sent_q[$];
  int n_send = 0;
  int n_done = 0;
  int n_fail = 0;
  int n_ack = 0;
  always @(negedge clk) begin
    if (ifc.SEND_BYTE === 1'b1) begin
      n_send++;
      sent_q.push_back(ifc.BYTE_TO_SEND);
    end
    if (ifc.CMD_DONE === 1'b1) n_done++;
    if (ifc.CMD_FAIL === 1'b1) n_fail++;
    if (ifc.PRIO_ACK === 1'b1) n_ack++;
  end

  // Responder: [7:0] byte, [8] BYTE_READY, [9] error code
  logic [9:0] resp_q[$];
  logic [9:0] rsp;
  bit hold_sent = 1'b0;
  initial begin
    ifc.BYTE_SENT = 1'b0;
    ifc.BYTE_READY = 1'b0;
    ifc.BYTE_READ = 8'h00;
    ifc.BYTE_ERROR_CODE = 2'b00;
    forever begin
      @(negedge clk);
      if (ifc.SEND_BYTE === 1'b1 && !hold_sent) begin
        repeat (2) @(negedge clk);
        ifc.BYTE_SENT = 1'b1;
        @(negedge clk);
        ifc.BYTE_SENT = 1'b0;
        if (resp_q.size() != 0) begin
          rsp = resp_q.pop_front();
          repeat (2) @(negedge clk);
          ifc.BYTE_READ = rsp[7:0];
          ifc.BYTE_READY = rsp[8];
          ifc.BYTE_ERROR_CODE = rsp[9] ? 2'b10 : 2'b00;
          @(negedge clk);
          ifc.BYTE_READY = 1'b0;
          ifc.BYTE_ERROR_CODE = 2'b00;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    ifc.CMD_WR = 1'b1;
    ifc.CMD_DATA = b;
    @(negedge clk);
    ifc.CMD_WR = 1'b0;
  endtask

  task automatic wait_ends(input int target,
                           input string name);
    int k = 0;
    while (n_done + n_fail < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      checks++;
      errs++;
      $display("FAIL %s timeout: ends=%0d required=%0d",
               name, n_done + n_fail, target);
    end
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]      cmd;
    bit              no_sent;
    int              n_rsp;
    logic [0:3][9:0] rsp;
    int              sends;
    int              done;
    int              fail;
    logic [7:0]      last;
  } vec_t;

  vec_t vt[9];
  logic [7:0] exp_full[6];
  int s0, d0, f0, a0;
  int exp_retry, exp_fails, k;

  initial begin
    vt[0] = '{8'hF3, 1'b0, 1,
              {10'h1FA, 10'h0, 10'h0, 10'h0}, 1, 1, 0, 8'hFA};
    vt[1] = '{8'hF4, 1'b0, 3,
              {10'h1FE, 10'h1FE, 10'h1FA, 10'h0}, 3, 1, 0, 8'hFA};
    vt[2] = '{8'hE6, 1'b0, 2,
              {10'h1FC, 10'h1FA, 10'h0, 10'h0}, 2, 1, 0, 8'hFA};
    vt[3] = '{8'hE8, 1'b0, 0,
              {10'h0, 10'h0, 10'h0, 10'h0}, 4, 0, 1, 8'hFA};
    vt[4] = '{8'hEA, 1'b0, 3,
              {10'h200, 10'h3AA, 10'h1FA, 10'h0}, 3, 1, 0, 8'hFA};
    vt[5] = '{8'hF2, 1'b0, 4,
              {10'h3AA, 10'h3AA, 10'h3AA, 10'h200}, 4, 0, 1, 8'hFA};
    vt[6] = '{8'hFF, 1'b0, 4,
              {10'h1FE, 10'h1FE, 10'h1FE, 10'h1FE}, 4, 0, 1, 8'hFE};
    vt[7] = '{8'hF0, 1'b1, 0,
              {10'h0, 10'h0, 10'h0, 10'h0}, 4, 0, 1, 8'hFE};
    vt[8] = '{8'hF6, 1'b0, 2,
              {10'h1EE, 10'h1FA, 10'h0, 10'h0}, 2, 1, 0, 8'hFA};
    exp_full = '{8'h10, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14};

    rst = 1'b1;
    ifc.CMD_WR = 1'b0;
    ifc.CMD_DATA = 8'h00;
    ifc.PRIO_REQ = 1'b0;
    ifc.PRIO_BYTE = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst busy", ifc.BUSY, 0);
    chk("rst empty", ifc.CMD_EMPTY, 1);
    chk("rst full", ifc.CMD_FULL, 0);
    chk("rst send", ifc.SEND_BYTE, 0);
    chk("rst tx byte", ifc.BYTE_TO_SEND, 0);
    chk("rst read_en", ifc.READ_ENABLE, 0);
    chk("rst ack", ifc.PRIO_ACK, 0);
    chk("rst done", ifc.CMD_DONE, 0);
    chk("rst fail", ifc.CMD_FAIL, 0);
    chk("rst last", ifc.LAST_RESP, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Two queued bytes, each acknowledged
    sent_q.delete();
    resp_q = '{10'h1FA, 10'h1FA};
    d0 = n_done;
    f0 = n_fail;
    push(8'hF3);
    push(8'h28);
    wait_ends(d0 + f0 + 2, "pair");
    chk("pair sends", sent_q.size(), 2);
    if (sent_q.size() == 2) begin
      chk("pair byte0", sent_q[0], 8'hF3);
      chk("pair byte1", sent_q[1], 8'h28);
    end
    chk("pair done", n_done - d0, 2);
    chk("pair fail", n_fail - f0, 0);
    chk("pair last", ifc.LAST_RESP, 8'hFA);
    chk("pair empty", ifc.CMD_EMPTY, 1);
    chk("pair busy", ifc.BUSY, 0);

    // Table of single-command scenarios
    exp_retry = 0;
    exp_fails = 0;
    for (int i = 0; i < 9; i++) begin
      sent_q.delete();
      resp_q.delete();
      for (int j = 0; j < vt[i].n_rsp; j++)
        resp_q.push_back(vt[i].rsp[j]);
      hold_sent = vt[i].no_sent;
      s0 = n_send;
      d0 = n_done;
      f0 = n_fail;
      push(vt[i].cmd);
      wait_ends(d0 + f0 + 1, $sformatf("v%0d", i));
      hold_sent = 1'b0;
      chk($sformatf("v%0d sends", i), n_send - s0, vt[i].sends);
      chk($sformatf("v%0d done", i), n_done - d0, vt[i].done);
      chk($sformatf("v%0d fail", i), n_fail - f0, vt[i].fail);
      chk($sformatf("v%0d last", i), ifc.LAST_RESP, vt[i].last);
      chk($sformatf("v%0d busy", i), ifc.BUSY, 0);
      chk($sformatf("v%0d empty", i), ifc.CMD_EMPTY, 1);
      for (int j = 0; j < sent_q.size(); j++)
        chk($sformatf("v%0d byte%0d", i, j), sent_q[j], vt[i].cmd);
      exp_retry += vt[i].sends - 1;
      exp_fails += vt[i].fail;
    end
`ifdef PS2_SCHED_STATS_EN
    chk("stat fails", ifc.FAIL_COUNT, exp_fails);
    chk("stat retries", ifc.RETRY_COUNT, exp_retry);
`endif

    // Priority request against a queued byte in the same IDLE cycle
    sent_q.delete();
    resp_q = '{10'h1FA, 10'h1FA};
    d0 = n_done;
    f0 = n_fail;
    a0 = n_ack;
    push(8'hF3);
    ifc.PRIO_REQ = 1'b1;
    ifc.PRIO_BYTE = 8'hFF;
    @(negedge clk);
    chk("prio ack pulse", ifc.PRIO_ACK, 1);
    chk("prio no send yet", ifc.SEND_BYTE, 0);
    chk("prio queued", ifc.CMD_EMPTY, 0);
    ifc.PRIO_REQ = 1'b0;
    @(negedge clk);
    chk("prio ack width", ifc.PRIO_ACK, 0);
    chk("prio send lat", ifc.SEND_BYTE, 1);
    chk("prio tx byte", ifc.BYTE_TO_SEND, 8'hFF);
    wait_ends(d0 + f0 + 2, "prio");
    chk("prio acks", n_ack - a0, 1);
    chk("prio sends", sent_q.size(), 2);
    if (sent_q.size() == 2) begin
      chk("prio first", sent_q[0], 8'hFF);
      chk("prio second", sent_q[1], 8'hF3);
    end
    chk("prio done", n_done - d0, 2);

    // Fill the FIFO while the sender is stalled in WAIT_SENT
    sent_q.delete();
    resp_q = '{10'h1FA, 10'h1FA, 10'h1FA, 10'h1FA, 10'h1FA};
    hold_sent = 1'b1;
    d0 = n_done;
    f0 = n_fail;
    push(8'h10);
    k = 0;
    while (ifc.BUSY !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("full stall busy", ifc.BUSY, 1);
    repeat (3) @(negedge clk);
    push(8'h11);
    push(8'h12);
    push(8'h13);
    chk("full after 3", ifc.CMD_FULL, 0);
    push(8'h14);
    chk("full after 4", ifc.CMD_FULL, 1);
    push(8'h15);
    chk("full after 5", ifc.CMD_FULL, 1);
    chk("full not empty", ifc.CMD_EMPTY, 0);
    hold_sent = 1'b0;
    wait_ends(d0 + f0 + 5, "full");
    chk("full sends", sent_q.size(), 6);
    for (int j = 0; j < 6 && j < sent_q.size(); j++)
      chk($sformatf("full byte%0d", j), sent_q[j], exp_full[j]);
    chk("full done", n_done - d0, 5);
    chk("full drained", ifc.CMD_EMPTY, 1);
    exp_retry += 1;
`ifdef PS2_SCHED_STATS_EN
    chk("stat retries 2", ifc.RETRY_COUNT, exp_retry);
`endif

    // Reset while waiting for the mouse response
    resp_q.delete();
    push(8'hF4);
    k = 0;
    while (ifc.READ_ENABLE !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("mid wait_ack", ifc.READ_ENABLE, 1);
    push(8'h33);
    chk("mid queued", ifc.CMD_EMPTY, 0);
    s0 = n_send;
    d0 = n_done;
    f0 = n_fail;
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst busy", ifc.BUSY, 0);
    chk("mid rst empty", ifc.CMD_EMPTY, 1);
    chk("mid rst send", ifc.SEND_BYTE, 0);
    chk("mid rst read_en", ifc.READ_ENABLE, 0);
    chk("mid rst last", ifc.LAST_RESP, 0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("mid no sends", n_send - s0, 0);
    chk("mid no done", n_done - d0, 0);
    chk("mid no fail", n_fail - f0, 0);
    chk("mid idle", ifc.BUSY, 0);
`ifdef PS2_SCHED_STATS_EN
    chk("stat rst fails", ifc.FAIL_COUNT, 0);
    chk("stat rst retries", ifc.RETRY_COUNT, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1);
  end
endmodule

// File: doc/ps2_cmd_scheduler.md
Name: ps2_cmd_scheduler

Overview:
Sequences and arbitrates host-to-mouse PS/2 commands over the shared transmitter/receiver byte datapath. It holds a small FIFO of queued configuration bytes (for example F3 sample-rate + argument, E8 resolution + argument) plus a single high-priority request port for urgent resets/resends. It sends one byte at a time, waits for the mouse response, retries on NAK/error/timeout, and reports per-byte completion or failure. It sits between the command sources and the PS/2 transmitter/receiver, and takes over the byte channel when command traffic is required.

Parameters:
FIFO_DEPTH, 4, queued command bytes; power of 2, at least 2.
ADDR_W, 2, log2(FIFO_DEPTH).
TIMEOUT_CYCLES, 500000, maximum cycles spent in WAIT_SENT or WAIT_ACK per attempt at 50 MHz.
MAX_RETRIES, 3, re-sends after the first attempt before declaring failure.

Ports:
CLK  in  1  system clock, 50 MHz.
RESET  in  1  synchronous, active-high.
CMD_WR  in  1  push CMD_DATA into the FIFO.
CMD_DATA  in  8  queued command byte.
CMD_FULL  out  1  FIFO full.
CMD_EMPTY  out  1  FIFO empty.
PRIO_REQ  in  1  level request; held until PRIO_ACK.
PRIO_BYTE  in  8  priority byte; stable while PRIO_REQ=1.
PRIO_ACK  out  1  one-cycle pulse when the priority byte is accepted for sending.
SEND_BYTE  out  1  one-cycle transmit strobe.
BYTE_TO_SEND  out  8  byte to transmit; held until the next load.
BYTE_SENT  in  1  transmitter done pulse.
READ_ENABLE  out  1  receiver enable.
BYTE_READ  in  8  received byte.
BYTE_READY  in  1  received-byte strobe.
BYTE_ERROR_CODE  in  2  receiver error; nonzero means error.
BUSY  out  1  high in every state except IDLE.
CMD_DONE  out  1  one-cycle pulse: byte acknowledged with FA.
CMD_FAIL  out  1  one-cycle pulse: retries exhausted.
LAST_RESP  out  8  last byte received in WAIT_ACK.

Behaviour:
Reset values:
- All outputs 0, except CMD_EMPTY=1.
- State IDLE, FIFO pointers and count 0, retry count 0, timer 0.
- A reset mid-transaction abandons the transaction and flushes the FIFO. No DONE or FAIL pulse is generated.

FIFO:
- A write is accepted only when the registered CMD_FULL=0. A write to a full FIFO is dropped silently, even if a pop occurs in the same cycle.
- Simultaneous write and pop on a non-full FIFO leaves the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

State machine:
- IDLE:
  - PRIO_REQ=1 wins: latch PRIO_BYTE, pulse PRIO_ACK, retry count = 0, go to LOAD.
  - Otherwise, if the FIFO is not empty: pop the head, retry count = 0, go to LOAD.
  - Arbitration happens only in IDLE; an in-flight byte is never pre-empted.
- LOAD: SEND_BYTE=1 next cycle, BYTE_TO_SEND = latched byte, timer = 0, go to WAIT_SENT.
  - Latency from the IDLE decision to the SEND_BYTE pulse is 2 cycles.
- WAIT_SENT:
  - On BYTE_SENT: timer = 0, go to WAIT_ACK.
  - If timer reaches TIMEOUT_CYCLES-1: go to RETRY.
- WAIT_ACK: READ_ENABLE=1.
  - If BYTE_ERROR_CODE!=0: go to RETRY. This check has priority over BYTE_READY in the same cycle.
  - If BYTE_READY: LAST_RESP = BYTE_READ, then:
    - FA: go to DONE.
    - FE (resend): go to RETRY.
    - Any other value (FC included): go to RETRY.
  - If timer reaches TIMEOUT_CYCLES-1: go to RETRY.
- RETRY:
  - If retry count < MAX_RETRIES: increment it and go to LOAD (same byte).
  - Otherwise go to FAIL.
- DONE: CMD_DONE=1 for one cycle, go to IDLE.
- FAIL: CMD_FAIL=1 for one cycle, discard the byte, go to IDLE. Queued bytes are still sent afterwards.
- Illegal state encoding: go to IDLE and clear the timer.

Counters:
- Timer width is ceil(log2(TIMEOUT_CYCLES))+1 bits, zeroed on every state entry.
- Retry counter width is ceil(log2(MAX_RETRIES+1)) bits.

Optional Feature:
PS2_SCHED_STATS_EN:
- Defined: adds output FAIL_COUNT [7:0] and output RETRY_COUNT [7:0].
  - Both are saturating at 255 and cleared by RESET.
  - FAIL_COUNT increments on each CMD_FAIL pulse.
  - RETRY_COUNT increments on each RETRY-to-LOAD transition.
- Undefined: neither port nor their logic exists; all other behaviour is identical.

Test Plan:
1. Push F3 then 28; mouse answers FA to each -> two SEND_BYTE pulses with bytes F3 then 28, two CMD_DONE pulses, LAST_RESP=FA, CMD_EMPTY=1, BUSY=0.
2. Push F4; mouse answers FE twice then FA -> F4 sent 3 times, one CMD_DONE, no CMD_FAIL.
3. Push E8; never assert BYTE_READY -> after 4 attempts of TIMEOUT_CYCLES each (set to 100 in the bench), one CMD_FAIL pulse; with PS2_SCHED_STATS_EN, FAIL_COUNT=1 and RETRY_COUNT=3.
4. FIFO holds F3 and PRIO_REQ=1 with PRIO_BYTE=FF in the same IDLE cycle -> FF sent first with PRIO_ACK pulsed, then F3.
5. Write 5 bytes into a depth-4 FIFO while blocked -> CMD_FULL=1 after the 4th write, 5th byte dropped, only 4 bytes transmitted in order.
6. Assert RESET while in WAIT_ACK -> next cycle BUSY=0, CMD_EMPTY=1, no DONE or FAIL pulse, SEND_BYTE=0.
